// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO over a valid/ready interface.
// Queued bytes are sent back-to-back; the next start bit begins on the edge the stop bit ends.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        CLK_IN,
   input  logic                        RST_IN,
   input  logic [7:0]                  IN_DATA_i,
   input  logic                        IN_VALID_i,
   output logic                        IN_READY_o,
   output logic                        UART_TX_o,
   output logic                        BUSY_o,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT_o
);

   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]    count_q;
   state_e             state_q, state_d;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               push, pop, bit_done;

   // Ready depends only on the registered count, never on IN_VALID_i.
   assign IN_READY_o   = (count_q < CntW'(FIFO_DEPTH));
   assign push         = IN_VALID_i && IN_READY_o;
   assign bit_done     = (bit_cnt_q == BitCntW'(CLKS_PER_BIT - 1));
   assign UART_TX_o    = tx_q;
   assign BUSY_o       = busy_q;
   assign FIFO_COUNT_o = count_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_done ? '0 : bit_cnt_q + BitCntW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      pop       = 1'b0;
      case (state_q)
         StIdle: begin
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = StStart;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d   = StData;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         StData: begin
            if (bit_done) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         StStop: begin
            if (bit_done) begin
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = StStart;
                  tx_d    = 1'b0;
               end else begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) bit_cnt_d = '0;
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (push && !RST_IN) mem_q[wr_ptr_q] <= IN_DATA_i;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default and small divider) checked every cycle against a
// frame-level queue model, plus a mid-bit line decoder and directed timing checks.
module tb_uart_tx_fifo;

   localparam int C0 = 104;
   localparam int D0 = 4;
   localparam int C1 = 4;
   localparam int D1 = 2;

   typedef logic [7:0] bq_t [$];

   logic       clk = 1'b0;
   logic [1:0] rst_w;
   logic [1:0] vld;
   logic [7:0] dat [2];
   logic       rdy0, rdy1, tx0, tx1, busy0, busy1;
   logic [2:0] cnt0;
   logic [1:0] cnt1;
   logic [1:0] rdy_w, tx_w, busy_w;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model state: pending queue, accepted-not-yet-decoded queue, current frame position.
   bq_t        mq [2];
   bq_t        eq [2];
   bit         m_busy [2];
   int         m_t [2];
   logic [7:0] m_cur [2];
   bit         m_acc [2];
   int         gen [2];
   // Decoder state.
   bit         dec_on [2];
   int         dec_ph [2];
   int         dec_g [2];
   logic [7:0] dec_b [2];
   int         dec_n [2];

   logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};
   logic [7:0] decb  [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};

   assign rdy_w  = {rdy1, rdy0};
   assign tx_w   = {tx1, tx0};
   assign busy_w = {busy1, busy0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.CLKS_PER_BIT(C0), .FIFO_DEPTH(D0)) dut0 (
      .CLK_IN      (clk),
      .RST_IN      (rst_w[0]),
      .IN_DATA_i   (dat[0]),
      .IN_VALID_i  (vld[0]),
      .IN_READY_o  (rdy0),
      .UART_TX_o   (tx0),
      .BUSY_o      (busy0),
      .FIFO_COUNT_o(cnt0)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(D1)) dut1 (
      .CLK_IN      (clk),
      .RST_IN      (rst_w[1]),
      .IN_DATA_i   (dat[1]),
      .IN_VALID_i  (vld[1]),
      .IN_READY_o  (rdy1),
      .UART_TX_o   (tx1),
      .BUSY_o      (busy1),
      .FIFO_COUNT_o(cnt1)
   );

   function automatic int cpb(input int u);
      return (u == 0) ? C0 : C1;
   endfunction

   function automatic int dep(input int u);
      return (u == 0) ? D0 : D1;
   endfunction

   function automatic string pfx(input int u);
      return (u == 0) ? "u0" : "u1";
   endfunction

   function automatic logic [31:0] get_cnt(input int u);
      return (u == 0) ? 32'(cnt0) : 32'(cnt1);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int u, input logic r, input logic v, input logic [7:0] d);
      bit fe, dp;
      m_acc[u] = 1'b0;
      if (r) begin
         mq[u].delete();
         eq[u].delete();
         m_busy[u] = 1'b0;
         m_t[u]    = 0;
         gen[u]++;
         return;
      end
      fe = m_busy[u] && (m_t[u] == 10 * cpb(u) - 1);
      dp = (mq[u].size() > 0) && (!m_busy[u] || fe);
      m_acc[u] = (v === 1'b1) && (mq[u].size() < dep(u));
      if (m_busy[u]) m_t[u]++;
      if (fe) m_busy[u] = 1'b0;
      if (dp) begin
         m_cur[u]  = mq[u].pop_front();
         m_busy[u] = 1'b1;
         m_t[u]    = 0;
      end
      if (m_acc[u]) begin
         mq[u].push_back(d);
         eq[u].push_back(d);
      end
   endtask

   task automatic mon_check(input int u);
      int    idx;
      logic  et;
      string p = pfx(u);
      et = 1'b1;
      if (m_busy[u]) begin
         idx = m_t[u] / cpb(u);
         if (idx == 0) et = 1'b0;
         else if (idx <= 8) et = m_cur[u][idx-1];
      end
      check_val({p, ".tx"}, 32'(tx_w[u]), 32'(et));
      check_val({p, ".busy"}, 32'(busy_w[u]), 32'(m_busy[u]));
      check_val({p, ".count"}, get_cnt(u), mq[u].size());
      check_val({p, ".ready"}, 32'(rdy_w[u]), 32'(mq[u].size() < dep(u)));
   endtask

   // Line decoder: detects a start bit and samples every bit at its midpoint.
   task automatic decode_step(input int u);
      int    c = cpb(u);
      int    idx;
      string p = pfx(u);
      if (dec_on[u] && dec_g[u] != gen[u]) dec_on[u] = 1'b0;
      if (!dec_on[u]) begin
         if (tx_w[u] === 1'b0) begin
            dec_on[u] = 1'b1;
            dec_ph[u] = 0;
            dec_g[u]  = gen[u];
         end
      end else begin
         dec_ph[u]++;
         if (dec_ph[u] % c == c / 2) begin
            idx = dec_ph[u] / c;
            if (idx == 0) begin
               check_val({p, ".dec_start"}, 32'(tx_w[u]), 0);
            end else if (idx <= 8) begin
               dec_b[u][idx-1] = tx_w[u];
            end else begin
               check_val({p, ".dec_stop"}, 32'(tx_w[u]), 1);
               check_val({p, ".dec_pending"}, 32'(eq[u].size() > 0), 1);
               if (eq[u].size() > 0) check_val({p, ".dec_byte"}, 32'(dec_b[u]), 32'(eq[u].pop_front()));
               dec_n[u]++;
               dec_on[u] = 1'b0;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst_w[0], vld[0], dat[0]);
      model_step(1, rst_w[1], vld[1], dat[1]);
      #1;
      mon_check(0);
      mon_check(1);
      decode_step(0);
      decode_step(1);
   end

   task automatic drive(input int u, input logic v, input logic [7:0] d);
      vld[u] = v;
      dat[u] = d;
   endtask

   // Presents a byte and returns the edge index at which the model says it was accepted.
   task automatic push(input int u, input logic [7:0] d, input int budget, output int acc_at);
      int n = 0;
      @(negedge clk);
      drive(u, 1'b1, d);
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_acc[u] && n < budget);
      check_val({pfx(u), ".push_acc"}, 32'(m_acc[u]), 1);
      acc_at = cyc;
   endtask

   task automatic wait_idle(input int u, input int budget, output int e);
      int g = 0;
      while ((busy_w[u] !== 1'b0 || get_cnt(u) != 0) && g < budget) begin
         @(posedge clk);
         #1;
         g++;
      end
      check_val({pfx(u), ".idle"}, 32'(busy_w[u]), 0);
      e = cyc;
   endtask

   task automatic rand_drive(input int u, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!vld[u] || m_acc[u]) drive(u, ($urandom_range(0, 2) == 0), 8'($urandom));
      end
      @(negedge clk);
      drive(u, 1'b0, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, e, dn, hi, p1, p2, p3;
      int at [6];
      logic last;
      rst_w = 2'b11;
      vld   = 2'b00;
      dat[0] = 8'h00;
      dat[1] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         check_val({pfx(u), ".rst_tx"}, 32'(tx_w[u]), 1);
         check_val({pfx(u), ".rst_busy"}, 32'(busy_w[u]), 0);
         check_val({pfx(u), ".rst_count"}, get_cnt(u), 0);
         check_val({pfx(u), ".rst_ready"}, 32'(rdy_w[u]), 1);
      end
      @(negedge clk);
      rst_w = 2'b00;

      // Single byte: first-pop latency and frame length.
      push(0, 8'h55, 20, k);
      check_val("t1.count_accept", get_cnt(0), 1);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      check_val("t1.tx_fall", 32'(tx0), 0);
      check_val("t1.busy_rise", 32'(busy0), 1);
      check_val("t1.count_pop", get_cnt(0), 0);
      wait_idle(0, 3000, e);
      check_val("t1.frame_end", e - k, 1 + 10 * C0);

      // Burst with backpressure.
      for (int i = 0; i < 6; i++) begin
         push(0, burst[i], 3000, at[i]);
         if (i == 4) begin
            check_val("t2.peak", get_cnt(0), 4);
            check_val("t2.ready_low", 32'(rdy0), 0);
         end
      end
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      check_val("t2.five_fast", at[4] - at[0], 4);
      check_val("t2.sixth_accept", at[5] - at[0], 10 * C0 + 2);
      wait_idle(0, 8000, e);
      check_val("t2.total", e - at[0], 1 + 6 * 10 * C0);

      // Decoder recovery of edge-case bytes.
      dn = dec_n[0];
      for (int i = 0; i < 4; i++) push(0, decb[i], 3000, k);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      wait_idle(0, 6000, e);
      check_val("t3.decoded", dec_n[0] - dn, 4);
      check_val("t3.left", eq[0].size(), 0);

      // Reset during data bit 3 with a push presented during reset.
      dn = dec_n[0];
      push(0, 8'hA5, 20, k);
      push(0, 8'h11, 20, p1);
      push(0, 8'h22, 20, p2);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      while (cyc < k + 1 + 4 * C0 + C0 / 2) @(posedge clk);
      @(negedge clk);
      rst_w[0] = 1'b1;
      drive(0, 1'b1, 8'h99);
      @(posedge clk);
      #1;
      check_val("t4.tx", 32'(tx0), 1);
      check_val("t4.busy", 32'(busy0), 0);
      check_val("t4.count", get_cnt(0), 0);
      @(negedge clk);
      rst_w[0] = 1'b0;
      drive(0, 1'b0, 8'h00);
      repeat (12 * C0) @(posedge clk);
      #1;
      check_val("t4.quiet_busy", 32'(busy0), 0);
      check_val("t4.quiet_frames", dec_n[0] - dn, 0);
      push(0, 8'h3C, 20, k);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      wait_idle(0, 3000, e);
      check_val("t4.after_frames", dec_n[0] - dn, 1);
      check_val("t4.left", eq[0].size(), 0);

      // Small divider: 40-cycle frame and third push stalled until the first pop.
      dn = dec_n[1];
      push(1, 8'h01, 20, k);
      drive(1, 1'b0, 8'h00);
      fork
         begin
            hi = 0;
            last = 1'b0;
            for (int i = 0; i < 10 * C1; i++) begin
               @(posedge clk);
               #1;
               if (tx1) hi++;
               last = tx1;
            end
            check_val("t5.high_cycles", hi, 8);
            check_val("t5.stop_last", 32'(last), 1);
            @(posedge clk);
            #1;
            check_val("t5.next_start", 32'(tx1), 0);
         end
         begin
            repeat (2) @(posedge clk);
            push(1, 8'hC3, 20, p1);
            push(1, 8'h5A, 20, p2);
            check_val("t5.full", 32'(rdy1), 0);
            push(1, 8'hE7, 100, p3);
            check_val("t5.third_accept", p3 - k, 10 * C1 + 2);
            @(negedge clk);
            drive(1, 1'b0, 8'h00);
         end
      join
      wait_idle(1, 400, e);
      check_val("t5.decoded", dec_n[1] - dn, 4);

      // Random traffic on both instances.
      fork
         rand_drive(0, 6000);
         rand_drive(1, 3000);
      join
      wait_idle(0, 8000, e);
      wait_idle(1, 400, e);
      check_val("t6.left0", eq[0].size(), 0);
      check_val("t6.left1", eq[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
